// File: rtl/gap_pkg.sv
// gap_pkg: shared constants and state type
// for the gap analyser and gap_gen.
package gap_pkg;

  localparam int WIDTH   = 32;
  localparam int CNT_W   = 5;
  localparam int MAX_GAP = 30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } gap_gen_state_t;

endpackage

// File: rtl/gap_mask_gen.sv
// gap_mask_gen: builds the single-gap test mask
// and flags requests whose gap does not fit.
module gap_mask_gen
  import gap_pkg::MAX_GAP;
#(
  parameter int WIDTH = gap_pkg::WIDTH,
  parameter int CNT_W = gap_pkg::CNT_W
) (
  input  logic [CNT_W-1:0] gap_len,
  input  logic [CNT_W-1:0] gap_pos,
  output logic [WIDTH-1:0] mask,
  output logic             ok
);

  logic [CNT_W:0] lo;
  logic [CNT_W:0] hi;
  logic           fits;
  logic           len_ok;

  // zeros sit strictly above gap_pos, up to gap_pos+gap_len
  always_comb begin
    lo   = {1'b0, gap_pos};
    hi   = lo + {1'b0, gap_len};
    mask = '1;
    for (int i = 0; i < WIDTH; i++) begin
      if (((CNT_W+1)'(i) > lo) &&
          ((CNT_W+1)'(i) <= hi)) begin
        mask[i] = 1'b0;
      end
    end
  end

  // the upper bounding one must still be inside the word
  always_comb begin
    len_ok = {1'b0, gap_len} <= (CNT_W+1)'(MAX_GAP);
    fits   = (hi + 1'b1) <= (CNT_W+1)'(WIDTH-1);
    ok     = (gap_len == '0) || (len_ok && fits);
  end

endmodule

// File: rtl/gap_gen.sv
// gap_gen: serial/parallel test-word generator
// with one zero run of programmable length.
module gap_gen
  import gap_pkg::gap_gen_state_t;
  import gap_pkg::IDLE;
  import gap_pkg::SHIFT;
  import gap_pkg::DONE;
#(
  parameter int WIDTH = gap_pkg::WIDTH,
  parameter int CNT_W = gap_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] gap_len,
  input  logic [CNT_W-1:0] gap_pos,
  output logic             bit_out,
  output logic             bit_valid,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  gap_gen_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nxt;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_c;
  logic             ok_c;
  logic             last;

  gap_mask_gen #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mask (
    .gap_len (gap_len),
    .gap_pos (gap_pos),
    .mask    (mask_c),
    .ok      (ok_c)
  );

  // next bit index and end-of-word detect
  always_comb begin
    nxt  = cnt + 1'b1;
    last = (cnt == CNT_W'(WIDTH-1));
  end

  // bit 0 leaves on the accepting edge so bit i
  // is on the wire while cnt == i
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mask_q     <= '0;
      data       <= '0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && ok_c) begin
            state      <= SHIFT;
            mask_q     <= mask_c;
            cnt        <= '0;
            data       <= {{(WIDTH-1){1'b0}}, mask_c[0]};
            data_valid <= 1'b0;
            busy       <= 1'b1;
            bit_out    <= mask_c[0];
            bit_valid  <= 1'b1;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        SHIFT: begin
          cnt <= nxt;
          if (last) begin
            state      <= DONE;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            done       <= 1'b1;
            data_valid <= 1'b1;
          end else begin
            bit_out   <= mask_q[nxt];
            data[nxt] <= mask_q[nxt];
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          bit_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gap_gen.sv
// tb_gap_gen: directed checks of gap_gen words,
// rejects, ignored restarts and async reset.
module tb_gap_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  gap_len;
  logic [4:0]  gap_pos;
  logic        bit_out;
  logic        bit_valid;
  logic [31:0] data;
  logic        data_valid;
  logic        busy;
  logic        done;
  logic        err;

  int errors;
  int checks;

  gap_gen dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .gap_len    (gap_len),
    .gap_pos    (gap_pos),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .data       (data),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive one start pulse; returns just after edge T
  task automatic kick(input logic [4:0] l,
                      input logic [4:0] p);
    @(negedge clk);
    gap_len = l;
    gap_pos = p;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // collect the 32 serial bits, tally bad handshake cycles
  task automatic stream(output logic [31:0] ser,
                        output int bad);
    bad = 0;
    ser = '0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      ser[k] = bit_out;
      if (bit_valid !== 1'b1 || busy !== 1'b1 ||
          done !== 1'b0 || data_valid !== 1'b0 ||
          data[k] !== bit_out)
        bad++;
    end
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    start   = 1'b0;
    gap_len = '0;
    gap_pos = '0;
    #12;
    checks++;
    if ({bit_out, bit_valid, data_valid, busy, done, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b want=000000",
               {bit_out, bit_valid, data_valid, busy, done, err});
    end
    checks++;
    if (data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got=%h want=00000000", data);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bit_valid, busy, done, err} !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_reset got=%b want=0000",
               {bit_valid, busy, done, err});
    end
  endtask

  task automatic test_all_ones();
    logic [31:0] ser;
    int bad;
    kick(5'd0, 5'd7);
    stream(ser, bad);
    checks++;
    if (ser !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL ones_serial got=%h want=ffffffff", ser);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL ones_handshake got=%0d want=0", bad);
    end
    @(negedge clk);
    checks++;
    if ({done, data_valid, busy, bit_valid} !== 4'b1110) begin
      errors++;
      $display("FAIL ones_done got=%b want=1110",
               {done, data_valid, busy, bit_valid});
    end
    checks++;
    if (data !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL ones_data got=%h want=ffffffff", data);
    end
    @(negedge clk);
    checks++;
    if ({done, data_valid, busy} !== 3'b010) begin
      errors++;
      $display("FAIL ones_idle got=%b want=010",
               {done, data_valid, busy});
    end
  endtask

  task automatic test_gap5();
    logic [31:0] ser;
    int bad;
    kick(5'd5, 5'd3);
    stream(ser, bad);
    checks++;
    if (ser !== 32'hFFFF_FE0F) begin
      errors++;
      $display("FAIL gap5_serial got=%h want=fffffe0f", ser);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL gap5_handshake got=%0d want=0", bad);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || data !== 32'hFFFF_FE0F) begin
      errors++;
      $display("FAIL gap5_data got=%b/%h want=1/fffffe0f",
               done, data);
    end
    @(negedge clk);
  endtask

  task automatic test_boundary();
    logic [31:0] ser;
    int bad;
    kick(5'd30, 5'd0);
    stream(ser, bad);
    checks++;
    if (ser !== 32'h8000_0001 || bad !== 0) begin
      errors++;
      $display("FAIL edge_serial got=%h/%0d want=80000001/0",
               ser, bad);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || data_valid !== 1'b1 ||
        data !== 32'h8000_0001) begin
      errors++;
      $display("FAIL edge_data got=%b%b/%h want=11/80000001",
               done, data_valid, data);
    end
    @(negedge clk);
  endtask

  task automatic test_invalid();
    logic [4:0] ls [2];
    logic [4:0] ps [2];
    ls[0] = 5'd30; ps[0] = 5'd1;
    ls[1] = 5'd31; ps[1] = 5'd0;
    for (int r = 0; r < 2; r++) begin
      kick(ls[r], ps[r]);
      @(negedge clk);
      checks++;
      if ({err, busy, bit_valid, done} !== 4'b1000) begin
        errors++;
        $display("FAIL rej%0d_pulse got=%b want=1000",
                 r, {err, busy, bit_valid, done});
      end
      checks++;
      if (data !== 32'h8000_0001 || data_valid !== 1'b1) begin
        errors++;
        $display("FAIL rej%0d_keep got=%h/%b want=80000001/1",
                 r, data, data_valid);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rej%0d_end got=%b%b want=00",
                 r, err, busy);
      end
    end
  endtask

  task automatic test_restart_ignored();
    int ndone;
    int at;
    logic [31:0] d32;
    ndone = 0;
    at    = -1;
    d32   = '0;
    kick(5'd5, 5'd3);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        at  = k;
        d32 = data;
      end
      if (k == 9) begin
        start   = 1'b1;
        gap_len = 5'd0;
        gap_pos = 5'd0;
      end
      if (k == 10) start = 1'b0;
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL restart_count got=%0d want=1", ndone);
    end
    checks++;
    if (at !== 32) begin
      errors++;
      $display("FAIL restart_when got=%0d want=32", at);
    end
    checks++;
    if (d32 !== 32'hFFFF_FE0F) begin
      errors++;
      $display("FAIL restart_data got=%h want=fffffe0f", d32);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ser;
    int bad;
    int late;
    late = 0;
    kick(5'd5, 5'd3);
    repeat (15) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({bit_out, bit_valid, data_valid, busy, done, err} !== 6'b0) begin
      errors++;
      $display("FAIL midrst_flags got=%b want=000000",
               {bit_out, bit_valid, data_valid, busy, done, err});
    end
    checks++;
    if (data !== 32'h0) begin
      errors++;
      $display("FAIL midrst_data got=%h want=00000000", data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || bit_valid !== 1'b0)
        late++;
    end
    checks++;
    if (late !== 0) begin
      errors++;
      $display("FAIL midrst_quiet got=%0d want=0", late);
    end
    kick(5'd2, 5'd28);
    stream(ser, bad);
    checks++;
    if (ser !== 32'h9FFF_FFFF || bad !== 0) begin
      errors++;
      $display("FAIL post_serial got=%h/%0d want=9fffffff/0",
               ser, bad);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || data !== 32'h9FFF_FFFF) begin
      errors++;
      $display("FAIL post_data got=%b/%h want=1/9fffffff",
               done, data);
    end
    @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_all_ones();
    test_gap5();
    test_boundary();
    test_invalid();
    test_restart_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gap_gen.md
# gap_gen

Bit-serial test-word generator; the transmit-side counterpart of the `gap` analyser. On a start request it builds a 32-bit word whose only zero run is exactly `gap_len` zeros, bounded by ones, starting just above bit `gap_pos`. It streams the word LSB-first, one bit per clock, on `bit_out`, and assembles the same word in parallel on `data`. It sits in front of `gap` in the bench and system loopback, so every word has a known longest gap.

## Interface
- `WIDTH`, default 32: word width. Fixed at 32 for this revision.
- `CNT_W`, default 5: bit-counter and gap-field width, log2(WIDTH).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset. Asserting it (low) clears all state immediately.
- `start`  in  1  request pulse. Sampled only in IDLE.
- `gap_len`  in  5  number of zeros in the run, 0..30.
- `gap_pos`  in  5  index of the lower bounding one. Zeros occupy bits `gap_pos+1 .. gap_pos+gap_len`.
- `bit_out`  out  1  serial bit, LSB first.
- `bit_valid`  out  1  `bit_out` is meaningful this cycle.
- `data`  out  32  parallel word; bit i is written in the cycle bit i is emitted.
- `data_valid`  out  1  `data` is complete. Level signal.
- `busy`  out  1  request accepted and not yet done.
- `done`  out  1  one-cycle pulse after the last bit.
- `err`  out  1  one-cycle pulse: request rejected.

## Operation
- States:
  - IDLE: wait for `start`.
  - SHIFT: emit 32 bits, `cnt` = 0..31.
  - DONE: one cycle, then return to IDLE.
- Mask: `mask[i] = 0` for `gap_pos < i <= gap_pos+gap_len`; all other bits are 1.
  - `gap_len = 0` gives 0xFFFFFFFF, valid for any `gap_pos`.
- Validity (for `gap_len != 0`): `gap_pos + gap_len + 1 <= 31`.
  - Evaluate the sum at 6-bit width so it cannot wrap.
  - `gap_len = 31` is always invalid.
- IDLE with `start=1`:
  - Valid request: latch the mask, clear `data`, drop `data_valid`, set `cnt=0`, go to SHIFT.
  - Invalid request: pulse `err` next cycle and stay in IDLE. `data` and `data_valid` are unchanged.
- SHIFT each cycle: `bit_out = mask[cnt]`, `bit_valid=1`, `data[cnt] <= mask[cnt]`, `cnt <= cnt+1`.
- SHIFT exit: after `cnt = 31`, go to DONE. The counter wraps to 0, which is harmless.
- DONE: `done=1`, `data_valid` set and held until the next accepted start or reset. Return to IDLE.
- `start` outside IDLE is ignored; nothing is queued.
- Reset values: state IDLE, `cnt=0`, `data=0`, `bit_out=0`, and `bit_valid`, `data_valid`, `busy`, `done`, `err` all 0.

## Timing
- `start` sampled high at edge T (IDLE):
  - `busy` is high from T+1 through T+33.
  - Bit i is valid during cycle T+1+i, for i = 0..31.
  - `done` and `data_valid` rise at T+33.
  - IDLE again at T+34, ready for `start` sampled at edge T+34.
- Minimum request spacing: 34 cycles.
- All outputs are registered. `bit_out` and `data` change only on `clk`, except under reset.
- Invalid `start` at edge T: `err` is high for cycle T+1 only, and `busy` stays 0.
- `gap_len` and `gap_pos` are sampled only at the accepting edge. Changes during SHIFT have no effect.
- Reset mid-SHIFT:
  - Outputs clear immediately.
  - No `done` is issued.
  - The first edge after reset release is IDLE.

## Structure
- Shared package `gap_pkg`:
  - `WIDTH` and `CNT_W` constants.
  - `MAX_GAP = 30`.
  - State enum `gap_gen_state_t {IDLE, SHIFT, DONE}`.
  - `gap_pkg` is also imported by `gap`.
- Sub-module `gap_mask_gen` (combinational): inputs `gap_len`, `gap_pos`; outputs `mask[31:0]` and `ok`. It is reused by the bench scoreboard.
- The top level holds the FSM, counter, mask register and output registers.

## Test plan
- Reset, then `gap_len=0`, `gap_pos=7`, start -> 32 serial ones; `data=0xFFFFFFFF`; `done` at T+33.
- `gap_len=5`, `gap_pos=3` -> `data=0xFFFFFE0F`. The serial stream LSB-first is 1111 00000 1…1. Feeding `data` to `gap` yields gap=5.
- `gap_len=30`, `gap_pos=0` -> `data=0x80000001`, the boundary case.
- `gap_len=30`, `gap_pos=1` -> `err` pulse at T+1, `busy`=0, previous `data` retained. Repeat with `gap_len=31`, `gap_pos=0` -> same result.
- `start` re-pulsed at T+10 during SHIFT -> ignored; exactly one `done`, at T+33.
- `rst` driven low at T+15 of a run -> all outputs 0 immediately. After release, a new request with `gap_len=2`, `gap_pos=28` -> `data=0x9FFFFFFF`.
